// File: rtl/button_conditioner.sv
`default_nettype none
// ============================================================================
// button_conditioner : synchronise, debounce and pulse-encode push-buttons.
// Optional auto-repeat for masked keys is built when BTN_AUTOREPEAT_EN is defined.
// Revision: 1.0
// ============================================================================
module button_conditioner #(
  parameter int                N_KEYS          = 4,
  parameter logic [15:0]       DEBOUNCE_CYCLES = 16'd20000,
  parameter logic [23:0]       REPEAT_DELAY    = 24'd500000,
  parameter logic [23:0]       REPEAT_PERIOD   = 24'd150000,
  parameter logic [N_KEYS-1:0] REPEAT_MASK     = 4'b0011
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [N_KEYS-1:0] i_key_n,
  output logic [N_KEYS-1:0] o_press,
  output logic [N_KEYS-1:0] o_level,
  output logic              o_dropped
);

  localparam int              CNT_W   = $clog2(int'(DEBOUNCE_CYCLES));
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 16'd1);

  if (DEBOUNCE_CYCLES < 16'd2 || REPEAT_DELAY == 24'd0 || REPEAT_PERIOD == 24'd0 ||
      $bits(REPEAT_MASK) != N_KEYS) begin : g_bad_params
    $error("button_conditioner: illegal parameter combination");
  end

  logic [N_KEYS-1:0] sync1_q;
  logic [N_KEYS-1:0] sync2_q;
  logic [N_KEYS-1:0] samp;
  logic [N_KEYS-1:0] level_q;
  logic [N_KEYS-1:0] level_d;
  logic [N_KEYS-1:0] olevel_q;
  logic [N_KEYS-1:0] rise_q;
  logic [N_KEYS-1:0] rpt_req;
  logic [N_KEYS-1:0] req;
  logic [N_KEYS-1:0] win;
  logic [N_KEYS-1:0] press_q;
  logic              dropped_q;
  logic              dropped_d;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= i_key_n;
      sync2_q <= sync1_q;
    end
  end

  assign samp = ~sync2_q;

  for (genvar k = 0; k < N_KEYS; k++) begin : g_debounce
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             lvl_d;

    always_comb begin
      cnt_d = cnt_q;
      lvl_d = level_q[k];
      if (samp[k] == level_q[k]) begin
        cnt_d = '0;
      end else if (cnt_q == CNT_MAX) begin
        lvl_d = samp[k];
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end

    assign level_d[k] = lvl_d;
  end

  // o_level trails the debounce decision by one stage; rise_q marks its 0->1 edge
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      level_q  <= '0;
      olevel_q <= '0;
      rise_q   <= '0;
    end else begin
      level_q  <= level_d;
      olevel_q <= level_q;
      rise_q   <= level_q & ~olevel_q;
    end
  end

`ifdef BTN_AUTOREPEAT_EN
  typedef enum logic [1:0] {
    RPT_IDLE   = 2'd0,
    RPT_WAIT   = 2'd1,
    RPT_REPEAT = 2'd2
  } rpt_state_e;

  localparam logic [23:0] RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int          RCNT_W  = (RPT_MAX > 24'd1) ? $clog2(int'(RPT_MAX)) : 1;
  localparam logic [RCNT_W-1:0] DELAY_LAST  = RCNT_W'(REPEAT_DELAY - 24'd1);
  localparam logic [RCNT_W-1:0] PERIOD_LAST = RCNT_W'(REPEAT_PERIOD - 24'd1);

  for (genvar k = 0; k < N_KEYS; k++) begin : g_repeat
    if (REPEAT_MASK[k]) begin : g_fsm
      rpt_state_e        state_q;
      rpt_state_e        state_d;
      logic [RCNT_W-1:0] rcnt_q;
      logic [RCNT_W-1:0] rcnt_d;
      logic              req_d;

      always_ff @(posedge i_clk) begin
        if (i_rst) begin
          state_q <= RPT_IDLE;
          rcnt_q  <= '0;
        end else begin
          state_q <= state_d;
          rcnt_q  <= rcnt_d;
        end
      end

      // A released key always wins over a due repeat, so no pulse trails a release
      always_comb begin
        state_d = state_q;
        rcnt_d  = rcnt_q;
        req_d   = 1'b0;
        case (state_q)
          RPT_IDLE: begin
            if (rise_q[k]) begin
              state_d = RPT_WAIT;
              rcnt_d  = '0;
            end
          end
          RPT_WAIT: begin
            if (!olevel_q[k]) begin
              state_d = RPT_IDLE;
              rcnt_d  = '0;
            end else if (rcnt_q == DELAY_LAST) begin
              req_d   = 1'b1;
              state_d = RPT_REPEAT;
              rcnt_d  = '0;
            end else begin
              rcnt_d = rcnt_q + RCNT_W'(1);
            end
          end
          RPT_REPEAT: begin
            if (!olevel_q[k]) begin
              state_d = RPT_IDLE;
              rcnt_d  = '0;
            end else if (rcnt_q == PERIOD_LAST) begin
              req_d  = 1'b1;
              rcnt_d = '0;
            end else begin
              rcnt_d = rcnt_q + RCNT_W'(1);
            end
          end
          default: begin
            state_d = RPT_IDLE;
            rcnt_d  = '0;
          end
        endcase
      end

      assign rpt_req[k] = req_d;
    end else begin : g_none
      assign rpt_req[k] = 1'b0;
    end
  end
`else
  assign rpt_req = '0;
`endif

  assign req = rise_q | rpt_req;

  // Highest index wins; losers are simply discarded
  always_comb begin
    win = '0;
    for (int i = 0; i < N_KEYS; i++) begin
      if (req[i]) begin
        win = N_KEYS'(1) << i;
      end
    end
    dropped_d = |(req & ~win);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      press_q   <= '0;
      dropped_q <= 1'b0;
    end else begin
      press_q   <= win;
      dropped_q <= dropped_d;
    end
  end

  assign o_press   = press_q;
  assign o_level   = olevel_q;
  assign o_dropped = dropped_q;

endmodule
`default_nettype wire

// File: tb/tb_button_conditioner.sv
`default_nettype none
// ============================================================================
// tb_button_conditioner : table vectors, corner sequences and random stimulus
// checked against a sample-history reference model.
// Revision: 1.0
// ============================================================================
module tb_button_conditioner;

  localparam int         NK    = 4;
  localparam int         DB    = 4;
  localparam int         RD    = 20;
  localparam int         RP    = 8;
  localparam logic [3:0] RMASK = 4'b0011;
`ifdef BTN_AUTOREPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  logic       clk   = 1'b0;
  logic       rst   = 1'b1;
  logic [3:0] key_n = 4'hF;
  logic [3:0] o_press;
  logic [3:0] o_level;
  logic       o_dropped;

  always #5 clk = ~clk;

  button_conditioner #(
    .N_KEYS         (NK),
    .DEBOUNCE_CYCLES(16'd4),
    .REPEAT_DELAY   (24'd20),
    .REPEAT_PERIOD  (24'd8),
    .REPEAT_MASK    (RMASK)
  ) dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_key_n  (key_n),
    .o_press  (o_press),
    .o_level  (o_level),
    .o_dropped(o_dropped)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  // Reference model: pressed-sample history and debounced-level history
  logic [3:0] pin_h[$];
  logic [3:0] lvl_h[$];
  bit         sched[NK];
  int         next_t[NK];
  logic [3:0] exp_press   = '0;
  logic [3:0] exp_level   = '0;
  logic       exp_dropped = 1'b0;

  task automatic model_reset();
    pin_h = {};
    lvl_h = {};
    repeat (DB + 2) pin_h.push_back(4'h0);
    repeat (3) lvl_h.push_back(4'h0);
    for (int k = 0; k < NK; k++) begin
      sched[k]  = 1'b0;
      next_t[k] = 0;
    end
  endtask

  task automatic model_step();
    logic [3:0] l1, l2, l3, ev, rq, nl, smp;
    int         nreq;
    bit         all_diff;
    if (rst) begin
      model_reset();
      exp_press   = '0;
      exp_level   = '0;
      exp_dropped = 1'b0;
      return;
    end
    l1 = lvl_h[lvl_h.size()-1];
    l2 = lvl_h[lvl_h.size()-2];
    l3 = lvl_h[lvl_h.size()-3];
    exp_level = l1;
    ev = l2 & ~l3;
    rq = ev;
`ifdef BTN_AUTOREPEAT_EN
    for (int k = 0; k < NK; k++) begin
      if (RMASK[k]) begin
        if (!l2[k]) sched[k] = 1'b0;
        if (ev[k]) begin
          sched[k]  = 1'b1;
          next_t[k] = cyc + RD;
        end else if (sched[k] && cyc == next_t[k]) begin
          rq[k]     = 1'b1;
          next_t[k] = next_t[k] + RP;
        end
      end
    end
`endif
    exp_press = '0;
    nreq = 0;
    for (int k = 0; k < NK; k++) begin
      if (rq[k]) begin
        nreq++;
        exp_press    = '0;
        exp_press[k] = 1'b1;
      end
    end
    exp_dropped = (nreq > 1);
    pin_h.push_back(~key_n);
    nl = l1;
    for (int k = 0; k < NK; k++) begin
      all_diff = 1'b1;
      for (int j = 0; j < DB; j++) begin
        smp = pin_h[pin_h.size()-3-j];
        if (smp[k] == l1[k]) all_diff = 1'b0;
      end
      if (all_diff) nl[k] = ~l1[k];
    end
    lvl_h.push_back(nl);
    if (pin_h.size() > 32) void'(pin_h.pop_front());
    if (lvl_h.size() > 32) void'(lvl_h.pop_front());
  endtask

  task automatic check_model();
    n_checks++;
    if (o_press === exp_press && o_level === exp_level && o_dropped === exp_dropped) n_pass++;
    else $display("FAIL model cycle %0d: press=%b level=%b dropped=%b, expected press=%b level=%b dropped=%b",
                  cyc, o_press, o_level, o_dropped, exp_press, exp_level, exp_dropped);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    model_step();
    @(negedge clk);
    check_model();
  endtask

  typedef struct {
    int key;
    int pre;
    int gap;
    int hold;
    int rise;
    int first;
    int count;
  } vec_t;

  vec_t vecs[6];
  int   rise, first, cnt, drops, div;
  bit   pressed;

  initial begin
    vecs[0] = '{1, 0, 0, 100, 6, 7, (AR ? 11 : 1)};   // clean press, repeats while held
    vecs[1] = '{0, 1, 2, 40, 9, 10, (AR ? 4 : 1)};    // bounce at 0,1,3 then held
    vecs[2] = '{3, 3, 0, 0, -1, -1, 0};               // 3-sample glitch
    vecs[3] = '{2, 0, 0, 100, 6, 7, 1};               // unmasked key, no repeats
    vecs[4] = '{0, 0, 0, 4, 6, 7, 1};                 // exactly DB samples
    vecs[5] = '{2, 0, 0, 3, -1, -1, 0};               // one sample short

    rst = 1'b1;
    repeat (3) step();
    chk("reset press", o_press, 0);
    chk("reset level", o_level, 0);
    chk("reset dropped", o_dropped, 0);
    rst = 1'b0;
    repeat (10) step();

    for (int v = 0; v < 6; v++) begin
      rise = -1; first = -1; cnt = 0; drops = 0;
      for (int r = 0; r < 150; r++) begin
        pressed = (r < vecs[v].pre) ||
                  (r >= vecs[v].pre + vecs[v].gap && r < vecs[v].pre + vecs[v].gap + vecs[v].hold);
        key_n = 4'hF;
        if (pressed) key_n[vecs[v].key] = 1'b0;
        step();
        if (o_level[vecs[v].key] && rise < 0) rise = r;
        if (o_press[vecs[v].key]) begin
          cnt++;
          if (first < 0) first = r;
        end
        if (o_dropped) drops++;
      end
      chk($sformatf("vec%0d level rise", v), rise, vecs[v].rise);
      chk($sformatf("vec%0d first pulse", v), first, vecs[v].first);
      chk($sformatf("vec%0d pulse count", v), cnt, vecs[v].count);
      chk($sformatf("vec%0d drops", v), drops, 0);
    end

    // KEY3 and KEY1 pressed together
    key_n = 4'b0101;
    for (int r = 0; r < 40; r++) begin
      step();
      if (r == 6) chk("simul level", o_level, 4'b1010);
      if (r == 7) begin
        chk("simul press", o_press, 4'b1000);
        chk("simul dropped", o_dropped, 1);
      end
      if (r == 27) chk("simul key1 repeat", o_press, AR ? 4'b0010 : 4'b0000);
    end
    key_n = 4'hF;
    repeat (20) step();

    // Reset pulse while KEY0 is held after its press
    key_n = 4'b1110;
    for (int r = 0; r < 12; r++) begin
      step();
      if (r == 7) chk("pre-rst press", o_press, 4'b0001);
    end
    rst = 1'b1;
    step();
    chk("rst press", o_press, 0);
    chk("rst level", o_level, 0);
    chk("rst dropped", o_dropped, 0);
    rst = 1'b0;
    for (int r = 13; r < 22; r++) begin
      step();
      if (r == 18) chk("post-rst level early", o_level, 0);
      if (r == 19) begin
        chk("post-rst level", o_level, 4'b0001);
        chk("post-rst press early", o_press, 0);
      end
      if (r == 20) chk("post-rst press", o_press, 4'b0001);
      if (r == 21) chk("post-rst press single", o_press, 0);
    end
    key_n = 4'hF;
    repeat (20) step();

    // Random bouncing and holding on all keys, occasional resets
    for (int blk = 0; blk < 24; blk++) begin
      case ($urandom_range(3))
        0:       div = 3;
        1:       div = 12;
        2:       div = 40;
        default: div = 80;
      endcase
      for (int c = 0; c < 200; c++) begin
        for (int k = 0; k < NK; k++) begin
          if ($urandom_range(div - 1) == 0) key_n[k] = ~key_n[k];
        end
        rst = ($urandom_range(599) == 0);
        step();
      end
    end
    rst = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/button_conditioner.md
# button_conditioner

Front-end for the four user push-buttons (KEY[3:0]). It synchronises the raw active-low pins into the `i_clk` domain and debounces each key. Each qualified press becomes a single-cycle pulse that drives the top-level menu FSM inputs `i_select`, `i_back`, `i_up` and `i_down`. Held keys in a repeat mask produce auto-repeat pulses, so gain and offset can be stepped without repeated tapping.

## Interface
Parameters:
- `N_KEYS`, 4: number of keys. Bit 3 = select, 2 = back, 1 = up, 0 = down.
- `DEBOUNCE_CYCLES`, 16'd20000: consecutive stable samples required before a level change is accepted. Must be ≥2.
- `REPEAT_DELAY`, 24'd500000: cycles from a press pulse to the first repeat pulse.
- `REPEAT_PERIOD`, 24'd150000: cycles between subsequent repeat pulses.
- `REPEAT_MASK`, 4'b0011: keys eligible for auto-repeat (up, down).

Ports:
- `i_clk`, in, 1: system clock. One clock only.
- `i_rst`, in, 1: reset. Synchronous, active-high.
- `i_key_n`, in, N_KEYS: raw pins, active-low (0 = pressed). Asynchronous to `i_clk`.
- `o_press`, out, N_KEYS: single-cycle press/repeat pulses. At most one bit set per cycle.
- `o_level`, out, N_KEYS: debounced level, active-high (1 = held).
- `o_dropped`, out, 1: one-cycle flag; pulses when arbitration discarded a pulse this cycle.

## Operation
- Synchroniser: two flops per key on `i_key_n`, followed by inversion. Sample `s[k]` = 1 means pressed.
- Debounce, per key, counter `cnt[k]` of width clog2(DEBOUNCE_CYCLES):
  - If `s[k] == level[k]`: `cnt[k]` <= 0.
  - Else if `cnt[k] == DEBOUNCE_CYCLES-1`: `level[k]` <= `s[k]` and `cnt[k]` <= 0.
  - Else: `cnt[k]` increments.
  - Any single glitch sample equal to the current level restarts the count.
- Press event: `level[k]` rising edge (0→1). Release produces no pulse.
- Repeat FSM per key in REPEAT_MASK, states IDLE, WAIT, REPEAT:
  - IDLE→WAIT on a press event; load `rcnt` = 0.
  - WAIT: `rcnt` increments each cycle. At `rcnt == REPEAT_DELAY-1`, emit a repeat request, go to REPEAT, and set `rcnt` = 0.
  - REPEAT: at `rcnt == REPEAT_PERIOD-1`, emit a repeat request and set `rcnt` = 0.
  - Any state → IDLE in the cycle `level[k]` falls. No request is emitted in that cycle.
  - Keys not in the mask stay in IDLE.
- Arbitration: requests are press events OR repeat requests. If more than one key requests in the same cycle, the highest index wins, so select beats back beats up beats down. Losers are discarded, not queued, and `o_dropped` = 1. A discarded press does not affect that key's repeat FSM, which still enters WAIT.
- `o_press` and `o_dropped` are registered from the arbitrated request.

## Timing
- Reset values:
  - synchroniser flops = 1 (released)
  - `level` = 0, `cnt` = 0, `rcnt` = 0
  - repeat FSMs = IDLE
  - `o_press` = 0, `o_level` = 0, `o_dropped` = 0
- Latency: a pin falling edge sampled at edge 0, and held clean, gives `o_level[k]` = 1 after edge 2+DEBOUNCE_CYCLES. `o_press[k]` = 1 in the next cycle only (edge 3+DEBOUNCE_CYCLES).
- Release latency is symmetric: 2+DEBOUNCE_CYCLES to `o_level` falling.
- Repeat pulses for a held masked key fall at press-pulse cycle + REPEAT_DELAY, then every REPEAT_PERIOD cycles.
- Reset asserted mid-press clears all state. If the key is still held after reset release, it is treated as a new press, with full debounce latency from the first post-reset sample.
- Simultaneous press and release of different keys are independent. Only pulses are arbitrated; `o_level` is never arbitrated.

## Configuration
- `BTN_AUTOREPEAT_EN`:
  - Defined: repeat FSMs and `rcnt` counters are built as above.
  - Undefined: no repeat logic is synthesised. `o_press` carries press events only, and REPEAT_DELAY, REPEAT_PERIOD and REPEAT_MASK are ignored.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4, `REPEAT_DELAY`=20, `REPEAT_PERIOD`=8.
- Clean press of KEY1, held 100 cycles from cycle 10:
  - `o_level[1]` rises at cycle 16.
  - `o_press` = 4'b0010 only at cycle 17.
  - With `BTN_AUTOREPEAT_EN`: repeats at 37, 45, 53, … until release.
- Bounce on KEY0: toggles at 10, 11, 13, then held low. Exactly one `o_press[0]` pulse, at 13+2+4+1 = 20.
- 3-cycle glitch on KEY3: no `o_level` change and no pulse.
- KEY3 and KEY1 pressed in the same cycle:
  - `o_press` = 4'b1000 and `o_dropped` = 1 in the same cycle.
  - KEY1 repeat pulses still start 20 cycles later.
- KEY2 held 100 cycles: a single pulse and no repeats (not in REPEAT_MASK).
- `i_rst` pulsed for 1 cycle while KEY0 is held after its press:
  - Outputs are 0 in the cycle after reset.
  - A new `o_press[0]` follows 7 cycles after reset deassertion.
